// File: rtl/uart_tx_scheduler.sv
// Round-robin arbiter sharing one 8N1 UART tx line; grant and ack land in the same clock that req is seen in IDLE.
// No internal queuing: requesters hold req until their ack, and nothing is granted while a frame is in flight.
module uart_tx_scheduler #(
   parameter int NUM_REQ = 4,
   parameter int DBITS   = 8,
   parameter int SB_TICK = 16,
   parameter int OS      = 16
) (
   input  logic                         clk_100MHz,
   input  logic                         reset,
   input  logic                         tick,
   input  logic [NUM_REQ-1:0]           req,
   input  logic [NUM_REQ*DBITS-1:0]     data_in,
   output logic [NUM_REQ-1:0]           ack,
   output logic [$clog2(NUM_REQ)-1:0]   grant_id,
   output logic                         busy,
   output logic                         tx
);
   localparam int PW   = $clog2(NUM_REQ);
   localparam int TMAX = (OS > SB_TICK) ? OS : SB_TICK;
   localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
   localparam int BW   = (DBITS > 1) ? $clog2(DBITS) : 1;

   localparam logic [TW-1:0] OS_LAST = TW'(OS - 1);
   localparam logic [TW-1:0] SB_LAST = TW'(SB_TICK - 1);
   localparam logic [BW-1:0] DB_LAST = BW'(DBITS - 1);
   localparam logic [PW-1:0] PTR_MAX = PW'(NUM_REQ - 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_START = 2'd1;
   localparam logic [1:0] S_DATA  = 2'd2;
   localparam logic [1:0] S_STOP  = 2'd3;

   logic [1:0]       state_q, state_d;
   logic [PW-1:0]    ptr_q, ptr_d;
   logic [TW-1:0]    tcnt_q, tcnt_d;
   logic [BW-1:0]    bcnt_q, bcnt_d;
   logic [DBITS-1:0] shift_q, shift_d;
   logic [PW-1:0]    gid_q, gid_d;
   logic             busy_q, busy_d;

   logic [PW-1:0]    win;
   logic [PW-1:0]    idx;
   logic             req_any;
   logic             grant_c;

   // Scan from the farthest candidate back to ptr so the nearest set bit wins.
   always_comb begin
      win     = ptr_q;
      idx     = ptr_q;
      req_any = 1'b0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         idx = PW'((int'(ptr_q) + k) % NUM_REQ);
         if (req[idx]) begin
            win     = idx;
            req_any = 1'b1;
         end
      end
   end

   assign grant_c = (state_q == S_IDLE) && req_any;

   always_comb begin
      ack = '0;
      if (grant_c && !reset) ack[win] = 1'b1;
   end

   always_comb begin
      case (state_q)
         S_START: tx = 1'b0;
         S_DATA:  tx = shift_q[0];
         default: tx = 1'b1;
      endcase
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      tcnt_d  = tcnt_q;
      bcnt_d  = bcnt_q;
      shift_d = shift_q;
      gid_d   = gid_q;
      busy_d  = busy_q;
      case (state_q)
         S_IDLE: begin
            if (grant_c) begin
               for (int i = 0; i < NUM_REQ; i++)
                  if (win == PW'(i)) shift_d = data_in[i*DBITS +: DBITS];
               gid_d   = win;
               ptr_d   = (win == PTR_MAX) ? '0 : win + 1'b1;
               tcnt_d  = '0;
               busy_d  = 1'b1;
               state_d = S_START;
            end
         end
         S_START: begin
            if (tick) begin
               if (tcnt_q == OS_LAST) begin
                  tcnt_d  = '0;
                  bcnt_d  = '0;
                  state_d = S_DATA;
               end else begin
                  tcnt_d = tcnt_q + 1'b1;
               end
            end
         end
         S_DATA: begin
            if (tick) begin
               if (tcnt_q == OS_LAST) begin
                  tcnt_d  = '0;
                  shift_d = shift_q >> 1;
                  if (bcnt_q == DB_LAST) state_d = S_STOP;
                  else                   bcnt_d  = bcnt_q + 1'b1;
               end else begin
                  tcnt_d = tcnt_q + 1'b1;
               end
            end
         end
         default: begin
            if (tick) begin
               if (tcnt_q == SB_LAST) begin
                  tcnt_d  = '0;
                  busy_d  = 1'b0;
                  state_d = S_IDLE;
               end else begin
                  tcnt_d = tcnt_q + 1'b1;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk_100MHz or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         ptr_q   <= '0;
         tcnt_q  <= '0;
         bcnt_q  <= '0;
         shift_q <= '0;
         gid_q   <= '0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         tcnt_q  <= tcnt_d;
         bcnt_q  <= bcnt_d;
         shift_q <= shift_d;
         gid_q   <= gid_d;
         busy_q  <= busy_d;
      end
   end

   assign grant_id = gid_q;
   assign busy     = busy_q;

endmodule
